// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: segment sizing and the
// per-stage control word that travels alongside the datapath.
package adder_pkg;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  function automatic int unsigned min_u(input int unsigned x, input int unsigned y);
    return (x < y) ? x : y;
  endfunction

  // Bits per ripple segment; the last segment takes whatever is left.
  function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
    return ceil_div(width, stages);
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple segments.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_carry;
  assign o_carry = (i_a & i_b) | (i_carry & (i_a ^ i_b));

endmodule

// File: rtl/rca_segment.sv
// Combinational W-bit ripple-carry segment built from full_adder cells.
module rca_segment #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_carry,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);

  logic [W:0] c;

  assign c[0] = i_carry;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .i_a    (i_a[i]),
      .i_b    (i_b[i]),
      .i_carry(c[i]),
      .o_sum  (o_sum[i]),
      .o_carry(c[i+1])
    );
  end

  assign o_carry = c[W];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one ripple segment per register stage, whole-pipe
// stall on output backpressure, {carry, sum} result plus signed-overflow flag.
module pipelined_rca_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 35,
  parameter int unsigned STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_carry,
  input  logic             i_sub,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int unsigned SegW = seg_width(WIDTH, STAGES);

  logic             en;
  logic [WIDTH-1:0] b_mode;
  logic             cin0;
  logic             ov_q;

  assign en      = !o_valid || i_ready;
  assign o_ready = en;
  assign b_mode  = i_sub ? ~i_add_term2 : i_add_term2;
  assign cin0    = i_sub | i_carry;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Lo      = min_u(k * SegW, WIDTH);
    localparam int unsigned Hi      = min_u((k + 1) * SegW, WIDTH);
    // Operand fields always keep at least the MSB so the last stage can form the overflow flag.
    localparam int unsigned InBase  = min_u(Lo, WIDTH - 1);
    localparam int unsigned OutBase = min_u(Hi, WIDTH - 1);
    localparam int unsigned InW     = WIDTH - InBase;
    localparam int unsigned OutW    = WIDTH - OutBase;

    logic [InW-1:0]  a_in, b_in;
    logic [OutW-1:0] a_d, b_d;
    logic [Hi-1:0]   sum_d, sum_q;
    stage_ctl_t      ctl_in, ctl_d, ctl_q;

    if (k == 0) begin : g_src
      assign a_in   = i_add_term1;
      assign b_in   = b_mode;
      assign ctl_in = '{valid: i_valid, carry: cin0};
    end else begin : g_src
      assign a_in   = g_stage[k-1].g_ops.a_q;
      assign b_in   = g_stage[k-1].g_ops.b_q;
      assign ctl_in = g_stage[k-1].ctl_q;
    end

    if (Hi > Lo) begin : g_seg
      logic [Hi-Lo-1:0] seg_sum;
      logic             seg_carry;

      rca_segment #(
        .W(Hi - Lo)
      ) u_seg (
        .i_a    (a_in[Hi-Lo-1:0]),
        .i_b    (b_in[Hi-Lo-1:0]),
        .i_carry(ctl_in.carry),
        .o_sum  (seg_sum),
        .o_carry(seg_carry)
      );

      if (k == 0) begin : g_sum
        assign sum_d = seg_sum;
      end else begin : g_sum
        assign sum_d = {seg_sum, g_stage[k-1].sum_q};
      end

      assign ctl_d = '{valid: ctl_in.valid, carry: seg_carry};
      assign a_d   = a_in[InW-1:OutBase-InBase];
      assign b_d   = b_in[InW-1:OutBase-InBase];
    end else begin : g_seg
      // Empty trailing segment: pure delay stage.
      assign sum_d = g_stage[k-1].sum_q;
      assign ctl_d = ctl_in;
      assign a_d   = a_in;
      assign b_d   = b_in;
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (en) begin
        ctl_q <= ctl_d;
        sum_q <= sum_d;
      end
    end

    if (k == STAGES - 1) begin : g_last
      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ov_q <= 1'b0;
        end else if (en) begin
          ov_q <= a_d[OutW-1] ^ b_d[OutW-1] ^ sum_d[Hi-1] ^ ctl_d.carry;
        end
      end
    end else begin : g_ops
      logic [OutW-1:0] a_q, b_q;

      always_ff @(posedge i_clk) begin
        if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign o_valid    = g_stage[STAGES-1].ctl_q.valid;
  assign o_result   = {g_stage[STAGES-1].ctl_q.carry, g_stage[STAGES-1].sum_q};
  assign o_overflow = ov_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Scoreboard bench for pipelined_rca_adder: directed corner beats, backpressure, mid-flight reset,
// and random traffic on STAGES=4 plus free-running random sweeps on STAGES=1, 3 and 35.
module tb_pipelined_rca_adder;

  localparam int unsigned W = 35;
  localparam int unsigned S = 4;

  typedef struct {
    logic [W:0] res;
    logic       ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] a, b;
  logic         c, sub, valid, ready_in;
  logic         dut_ready, dut_valid, dut_ov;
  logic [W:0]   dut_res;

  logic [W-1:0] sw_a, sw_b;
  logic         sw_c, sw_sub, sw_valid;
  logic         sweep_done = 1'b0;

  int checks = 0;
  int errors = 0;

  pipelined_rca_adder #(
    .WIDTH (W),
    .STAGES(S)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_add_term1(a),
    .i_add_term2(b),
    .i_carry    (c),
    .i_sub      (sub),
    .i_valid    (valid),
    .o_ready    (dut_ready),
    .o_result   (dut_res),
    .o_overflow (dut_ov),
    .o_valid    (dut_valid),
    .i_ready    (ready_in)
  );

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic tsub);
    exp_t   m;
    longint ua, ub, sa, sb, full, exact, lim;
    logic   cout;
    lim = longint'(1) << (W - 1);
    ua  = longint'(ta);
    ub  = longint'(tb);
    sa  = ta[W-1] ? ua - 2 * lim : ua;
    sb  = tb[W-1] ? ub - 2 * lim : ub;
    if (tsub) begin
      full  = ua - ub;
      cout  = (ua >= ub);
      exact = sa - sb;
    end else begin
      full  = ua + ub + longint'(tc);
      cout  = (full >= 2 * lim);
      exact = sa + sb + longint'(tc);
    end
    m.res = {cout, full[W-1:0]};
    m.ov  = (exact >= lim) || (exact < -lim);
    return m;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       r = 64'd0;
      1:       r = 64'h7_FFFF_FFFF;
      2:       r = 64'h4_0000_0000;
      3:       r = 64'h3_FFFF_FFFF;
      default: ;
    endcase
    return r[W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Main monitor: decisions made at negedge describe the transfers of the next posedge.
  exp_t       q[$];
  exp_t       mon_e;
  logic [W:0] seen[$];
  int         n_out = 0;
  logic       stall_vld = 1'b0;
  logic [W:0] stall_res;
  logic       stall_ov;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall_vld = 1'b0;
    end else begin
      if (stall_vld) begin
        check("hold_valid", 64'(dut_valid), 64'd1);
        check("hold_result", 64'(dut_res), 64'(stall_res));
        check("hold_overflow", 64'(dut_ov), 64'(stall_ov));
      end
      check("ready_rule", 64'(dut_ready), 64'(!dut_valid || ready_in));
      stall_vld = dut_valid && !ready_in;
      stall_res = dut_res;
      stall_ov  = dut_ov;
      if (dut_valid && ready_in) begin
        n_out++;
        seen.push_back(dut_res);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got %h want none", dut_res);
        end else begin
          mon_e = q.pop_front();
          check("result", 64'(dut_res), 64'(mon_e.res));
          check("overflow", 64'(dut_ov), 64'(mon_e.ov));
        end
      end
      if (valid && dut_ready) q.push_back(model(a, b, c, sub));
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned St = (g == 0) ? 1 : (g == 1) ? 3 : 35;
    logic       s_ready, s_valid, s_ov;
    logic [W:0] s_res;
    exp_t       sq[$];
    exp_t       se;

    pipelined_rca_adder #(
      .WIDTH (W),
      .STAGES(St)
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_add_term1(sw_a),
      .i_add_term2(sw_b),
      .i_carry    (sw_c),
      .i_sub      (sw_sub),
      .i_valid    (sw_valid),
      .o_ready    (s_ready),
      .o_result   (s_res),
      .o_overflow (s_ov),
      .o_valid    (s_valid),
      .i_ready    (1'b1)
    );

    always @(negedge clk) begin
      if (rst) begin
        sq.delete();
      end else begin
        if (s_valid) begin
          if (sq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sweep%0d_unexpected got %h want none", St, s_res);
          end else begin
            se = sq.pop_front();
            check($sformatf("sweep%0d_result", St), 64'(s_res), 64'(se.res));
            check($sformatf("sweep%0d_overflow", St), 64'(s_ov), 64'(se.ov));
          end
        end
        if (sw_valid && s_ready) sq.push_back(model(sw_a, sw_b, sw_c, sw_sub));
      end
    end

    always @(posedge sweep_done) check($sformatf("sweep%0d_drain", St), 64'(sq.size()), 64'd0);
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic tsub);
    logic hs;
    hs    = 1'b0;
    a     = ta;
    b     = tb;
    c     = tc;
    sub   = tsub;
    valid = 1'b1;
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk);
      hs = dut_ready;
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got no accept want accept");
    end
  endtask

  task automatic directed(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic tsub, input logic [W:0] wres, input logic wov);
    int lat;
    lat      = 0;
    a        = ta;
    b        = tb;
    c        = tc;
    sub      = tsub;
    valid    = 1'b1;
    ready_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) valid = 1'b0;
      if (dut_valid) begin
        lat = i;
        break;
      end
    end
    check("latency", 64'(lat), 64'(S));
    check("directed_result", 64'(dut_res), 64'(wres));
    check("directed_overflow", 64'(dut_ov), 64'(wov));
    @(posedge clk);
    #1;
  endtask

  task automatic backpressure();
    seen.delete();
    fork
      begin
        for (int n = 1; n <= 8; n++) send(W'(n), W'(n), 1'b0, 1'b0);
      end
      begin
        ready_in = 1'b1;
        for (int t = 0; t < 100 && seen.size() < 2; t++) begin
          @(posedge clk);
          #1;
        end
        ready_in = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        ready_in = 1'b1;
      end
    join
    for (int t = 0; t < 100 && seen.size() < 8; t++) begin
      @(posedge clk);
      #1;
    end
    check("bp_count", 64'(seen.size()), 64'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++) check("bp_order", 64'(seen[i]), 64'(2 * (i + 1)));
  endtask

  task automatic reset_mid();
    int base;
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) send(rand_op(), rand_op(), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = n_out;
    @(negedge clk);
    check("rst_mid_valid", 64'(dut_valid), 64'd0);
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    check("rst_mid_no_output", 64'(n_out), 64'(base));
  endtask

  task automatic random_phase();
    logic done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ready_in = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        ready_in = 1'b1;
      end
    join
    for (int t = 0; t < 200 && q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic sweep_drive();
    for (int i = 0; i < 400; i++) begin
      sw_valid = ($urandom_range(0, 3) != 0);
      sw_a     = rand_op();
      sw_b     = rand_op();
      sw_c     = 1'($urandom_range(0, 1));
      sw_sub   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    sw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic main_tests();
    directed(35'h3_FFFF_FFFF, 35'd1, 1'b0, 1'b0, 36'h4_0000_0000, 1'b1);
    directed(35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF, 1'b1, 1'b0, 36'hF_FFFF_FFFF, 1'b0);
    directed(35'd5, 35'd7, 1'b1, 1'b1, 36'h7_FFFF_FFFE, 1'b0);
    backpressure();
    reset_mid();
    random_phase();
  endtask

  initial begin
    rst      = 1'b1;
    valid    = 1'b1;
    a        = 35'h1234;
    b        = 35'h1;
    c        = 1'b0;
    sub      = 1'b0;
    ready_in = 1'b1;
    sw_valid = 1'b0;
    sw_a     = '0;
    sw_b     = '0;
    sw_c     = 1'b0;
    sw_sub   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    check("reset_valid", 64'(dut_valid), 64'd0);
    check("reset_result", 64'(dut_res), 64'd0);
    check("reset_overflow", 64'(dut_ov), 64'd0);
    check("reset_ready", 64'(dut_ready), 64'd1);
    @(posedge clk);
    #1;
    fork
      sweep_drive();
      main_tests();
    join
    sweep_done = 1'b1;
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. Successor to the combinational 35-bit RCA.
- The WIDTH-bit operation is split into STAGES ripple segments, with one register stage per segment. Carry passes between segments through pipeline registers; operand and result bits are skewed to match.
- Valid/ready handshake on input and output, with full backpressure. Adds a subtract mode, a carry-in and a signed-overflow flag.
- Sits between operand-sourcing logic and the result consumer in the adder test datapaths.

Parameters:
- WIDTH, 35, operand width in bits (>=2).
- STAGES, 4, pipeline segments/register stages (1..WIDTH). Each segment is SEG_W = ceil(WIDTH/STAGES) bits; the last segment takes the remainder.

Ports:
- i_clk  in  1  clock, all logic rising-edge.
- i_rst  in  1  synchronous, active-high reset.
- i_add_term1  in  WIDTH  operand A.
- i_add_term2  in  WIDTH  operand B.
- i_carry  in  1  carry-in; used in add mode only.
- i_sub  in  1  1 = A - B, 0 = A + B + i_carry.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block accepts a beat this cycle.
- o_result  out  WIDTH+1  {carry_out, sum}.
- o_overflow  out  1  two's-complement signed overflow of the WIDTH-bit sum.
- o_valid  out  1  o_result/o_overflow valid.
- i_ready  in  1  consumer accepts the output beat.

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge):
  - All stage valid bits clear; o_valid=0, o_result=0, o_overflow=0.
  - o_ready=1 from the first cycle after reset deasserts.
  - In-flight beats are discarded, never emitted.
- Advance enable: en = !o_valid || i_ready.
  - o_ready = en (combinational).
  - A beat is accepted when i_valid && o_ready.
  - When en=0, every stage register holds, including o_result/o_overflow/o_valid.
- Stall model: the pipeline stalls as a whole; bubbles are not collapsed. An invalid stage still advances when en=1.
- Mode handling at input:
  - B' = i_sub ? ~B : B.
  - cin0 = i_sub ? 1 : i_carry (i_carry ignored when i_sub=1).
- Stage k (0..STAGES-1):
  - Ripples segment k of A and B' with the carry from stage k-1's register (cin0 for k=0).
  - Registers the segment sum, the carry-out and the not-yet-processed upper operand bits.
  - Lower sum bits already computed are delayed alongside.
- Latency: exactly STAGES cycles from acceptance to o_valid, with no stalls. Throughput is one beat/cycle while i_ready=1.
- Outputs:
  - o_result[WIDTH] = final carry-out. In subtract mode 1 means no borrow (A>=B unsigned).
  - o_overflow = carry into MSB XOR carry out of MSB.
- Ordering: beats emerge strictly in acceptance order, with no loss or duplication under any i_ready pattern.
- Output stability: while o_valid=1 && i_ready=0, o_result and o_overflow are stable.
- Simultaneous accept and emit in one cycle is legal and required for full throughput.
- Reset asserted together with i_valid: the beat is dropped.

Decomposition:
- Shared package adder_pkg:
  - function ceil_div.
  - Constant SEG_W derivation.
  - Typedef for the stage payload struct {valid, sum_lo, a_hi, b_hi, carry}.
- One sub-module, rca_segment: a parametrised SEG_W-bit combinational ripple built from the existing full_adder cell, with i_carry/o_carry. Instantiated once per stage via generate.

Test Plan:
- Reset: hold i_rst 2 cycles with i_valid=1 -> o_valid=0, o_result=36'h0, o_ready=1 after release.
- Signed max plus one:
  - Stimulus: WIDTH=35, STAGES=4, add, A=35'h3_FFFF_FFFF, B=1, i_carry=0.
  - Response: 4 cycles later o_result=36'h4_0000_0000, o_overflow=1.
- All ones plus all ones:
  - Stimulus: add, A=B=35'h7_FFFF_FFFF, i_carry=1.
  - Response: o_result=36'hF_FFFF_FFFF, o_overflow=0.
- Subtract with borrow:
  - Stimulus: i_sub=1, A=5, B=7, i_carry=1 (must be ignored).
  - Response: o_result=36'h7_FFFF_FFFE (carry 0 = borrow), o_overflow=0.
- Backpressure:
  - Stimulus: 8 back-to-back beats A=n, B=n for n=1..8; i_ready low for 3 cycles after the 2nd output.
  - Response: outputs 2,4,...,16 in order; o_result stable during the stall; o_ready low while stalled with o_valid=1.
- Reset mid-operation: 3 beats in flight, pulse i_rst 1 cycle -> o_valid=0 next cycle; none of the 3 beats ever appear.
- Sweep: repeat the random add/sub comparison vs a reference model for STAGES=1, 3, 35.
